// File: rtl/ex_stage.sv
// MIPS32 execute stage: logic/shift/arith ALU plus a multi-cycle restoring divider.
// Define EX_DIV_EN to build the DIV/DIVU divider; without it divides are single-cycle NOPs.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_DIV   = 3'b101;

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;

  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] arith_res;
  logic [31:0] alu_res;
  logic [4:0]  shamt;

  logic        div_stall;
  logic        div_whilo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  assign shamt = reg1_i[4:0];

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      OP_SLL:  shift_res = reg2_i << shamt;
      OP_SRL:  shift_res = reg2_i >> shamt;
      OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> shamt);
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      OP_ADDU: arith_res = reg1_i + reg2_i;
      OP_SUBU: arith_res = reg1_i - reg2_i;
      OP_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
      default: arith_res = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alusel_i)
      SEL_LOGIC: alu_res = logic_res;
      SEL_SHIFT: alu_res = shift_res;
      SEL_ARITH: alu_res = arith_res;
      default:   alu_res = '0;
    endcase
  end

`ifdef EX_DIV_EN
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ZERO = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;

  logic        div_op;
  logic        div_signed;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] trial;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign div_op     = (alusel_i == SEL_DIV) && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
  assign div_signed = (aluop_i == OP_DIV);
  assign op1_abs    = (div_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
  assign op2_abs    = (div_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

  // The dividend register shifts out its MSB into the partial remainder and
  // shifts in quotient bits, so after the last step it holds the quotient.
  assign trial = {rem_q, dvd_q[31]} - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    case (state_q)
      ST_IDLE: begin
        if (div_op && !annul_i) begin
          cnt_d = '0;
          if (reg2_i == 32'd0) begin
            state_d    = ST_ZERO;
            dvd_d      = '1;
            rem_d      = reg1_i;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
          end else begin
            state_d    = ST_BUSY;
            dvd_d      = op1_abs;
            dvs_d      = op2_abs;
            rem_d      = '0;
            neg_quot_d = div_signed && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_d  = div_signed && reg1_i[31];
          end
        end
      end
      ST_BUSY: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            dvd_d = {dvd_q[30:0], 1'b1};
          end else begin
            rem_d = {rem_q[30:0], dvd_q[31]};
            dvd_d = {dvd_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(DIV_CYCLES - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ZERO: state_d = annul_i ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign quot_fix = neg_quot_q ? (32'd0 - dvd_q) : dvd_q;
  assign rem_fix  = neg_rem_q  ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    div_stall = 1'b0;
    div_whilo = 1'b0;
    div_hi    = '0;
    div_lo    = '0;
    case (state_q)
      ST_IDLE: div_stall = div_op && !annul_i;
      ST_BUSY: div_stall = !annul_i;
      ST_ZERO: div_stall = !annul_i;
      default: begin
        if (!annul_i) begin
          div_whilo = 1'b1;
          div_hi    = rem_fix;
          div_lo    = quot_fix;
        end
      end
    endcase
  end
`else
  localparam int unsigned UNUSED_DIV_CYCLES = DIV_CYCLES;
  logic unused_annul;

  assign unused_annul = annul_i;
  assign div_stall    = 1'b0;
  assign div_whilo    = 1'b0;
  assign div_hi       = '0;
  assign div_lo       = '0;
`endif

  // Every output is forced to zero while reset is asserted.
  assign wd_o       = rst ? wd_i : 5'd0;
  assign wreg_o     = rst && wreg_i && (alusel_i != SEL_NOP) && (alusel_i != SEL_DIV);
  assign wdata_o    = rst ? alu_res : 32'd0;
  assign whilo_o    = rst && div_whilo;
  assign hi_o       = rst ? div_hi : 32'd0;
  assign lo_o       = rst ? div_lo : 32'd0;
  assign stallreq_o = rst && div_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divider expectations follow EX_DIV_EN.
module tb_ex_stage;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_DIV   = 3'b101;

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  aluSel;
  logic [7:0]  aluOp;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wdIn;
  logic        wregIn;
  logic        annul;
  logic [4:0]  wdOut;
  logic        wregOut;
  logic [31:0] wdata;
  logic        whilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stallReq;

  int vectorCount = 0;
  int missCount   = 0;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alusel_i   (aluSel),
    .aluop_i    (aluOp),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wdIn),
    .wreg_i     (wregIn),
    .annul_i    (annul),
    .wd_o       (wdOut),
    .wreg_o     (wregOut),
    .wdata_o    (wdata),
    .whilo_o    (whilo),
    .hi_o       (hi),
    .lo_o       (lo),
    .stallreq_o (stallReq)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a hung run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one input vector just after the falling edge and let it settle.
  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] op,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg, input logic an);
    @(negedge clk);
    aluSel = sel;
    aluOp  = op;
    reg1   = r1;
    reg2   = r2;
    wdIn   = wd;
    wregIn = wreg;
    annul  = an;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue a divide, count the stall cycles (bounded) and check the result cycle.
  task automatic runDivide(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int expStall,
                           input logic [31:0] expLo, input logic [31:0] expHi);
    int stalls;
    stalls = 0;
    applyStimulus(SEL_DIV, op, a, b, 5'd4, 1'b1, 1'b0);
    while (stallReq === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_stalls"}, 32'(stalls), 32'(expStall));
    checkOutput({tag, "_whilo"}, {31'd0, whilo}, {31'd0, DIV_EN});
    checkOutput({tag, "_lo"}, lo, expLo);
    checkOutput({tag, "_hi"}, hi, expHi);
    checkOutput({tag, "_wreg"}, {31'd0, wregOut}, 32'd0);
    checkOutput({tag, "_wdata"}, wdata, 32'd0);
    applyStimulus(SEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checkOutput({tag, "_after_whilo"}, {31'd0, whilo}, 32'd0);
  endtask

  // Directed test sequence.
  initial begin
    int pulses;
    rst    = 1'b0;
    aluSel = SEL_LOGIC;
    aluOp  = OP_OR;
    reg1   = 32'h0000FF00;
    reg2   = 32'h00F0000F;
    wdIn   = 5'd3;
    wregIn = 1'b1;
    annul  = 1'b0;
    #2;
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_wd", {27'd0, wdOut}, 32'd0);
    checkOutput("rst_wreg", {31'd0, wregOut}, 32'd0);
    checkOutput("rst_stall", {31'd0, stallReq}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(SEL_LOGIC, OP_OR, 32'h0000FF00, 32'h00F0000F, 5'd3, 1'b1, 1'b0);
    checkOutput("ori_wdata", wdata, 32'h00F0FF0F);
    checkOutput("ori_wd", {27'd0, wdOut}, 32'd3);
    checkOutput("ori_wreg", {31'd0, wregOut}, 32'd1);
    checkOutput("ori_stall", {31'd0, stallReq}, 32'd0);

    applyStimulus(SEL_LOGIC, OP_AND, 32'hFFFF0000, 32'h12345678, 5'd7, 1'b1, 1'b0);
    checkOutput("and_wdata", wdata, 32'h12340000);
    applyStimulus(SEL_LOGIC, OP_XOR, 32'h0F0F0F0F, 32'hFF00FF00, 5'd7, 1'b1, 1'b0);
    checkOutput("xor_wdata", wdata, 32'hF00FF00F);
    applyStimulus(SEL_LOGIC, OP_NOR, 32'h0000FF00, 32'h00F0000F, 5'd7, 1'b1, 1'b0);
    checkOutput("nor_wdata", wdata, 32'hFF0F00F0);
    applyStimulus(SEL_LOGIC, 8'hFF, 32'h0000FF00, 32'h00F0000F, 5'd7, 1'b1, 1'b0);
    checkOutput("unk_wdata", wdata, 32'd0);
    checkOutput("unk_whilo", {31'd0, whilo}, 32'd0);

    applyStimulus(SEL_SHIFT, OP_SRA, 32'd4, 32'hF0000000, 5'd8, 1'b1, 1'b0);
    checkOutput("sra_wdata", wdata, 32'hFF000000);
    applyStimulus(SEL_SHIFT, OP_SRL, 32'd4, 32'hF0000000, 5'd8, 1'b1, 1'b0);
    checkOutput("srl_wdata", wdata, 32'h0F000000);
    applyStimulus(SEL_SHIFT, OP_SLL, 32'hFFFFFF08, 32'h000000AB, 5'd8, 1'b1, 1'b0);
    checkOutput("sll_wdata", wdata, 32'h0000AB00);

    applyStimulus(SEL_ARITH, OP_ADDU, 32'hFFFFFFFF, 32'd2, 5'd9, 1'b1, 1'b0);
    checkOutput("addu_wdata", wdata, 32'd1);
    applyStimulus(SEL_ARITH, OP_SUBU, 32'd1, 32'd2, 5'd9, 1'b1, 1'b0);
    checkOutput("subu_wdata", wdata, 32'hFFFFFFFF);
    applyStimulus(SEL_ARITH, OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd9, 1'b1, 1'b0);
    checkOutput("slt_wdata", wdata, 32'd1);
    applyStimulus(SEL_ARITH, OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd9, 1'b1, 1'b0);
    checkOutput("sltu_wdata", wdata, 32'd0);

    applyStimulus(SEL_NOP, 8'd0, 32'd5, 32'd6, 5'd10, 1'b1, 1'b0);
    checkOutput("nop_wreg", {31'd0, wregOut}, 32'd0);
    checkOutput("nop_wd", {27'd0, wdOut}, 32'd10);

    runDivide("divu_100_7", OP_DIVU, 32'd100, 32'd7, DIV_EN ? 33 : 0,
              DIV_EN ? 32'h0000000E : 32'd0, DIV_EN ? 32'h00000002 : 32'd0);
    runDivide("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_EN ? 33 : 0,
              DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0);
    runDivide("div_by_zero", OP_DIVU, 32'd5, 32'd0, DIV_EN ? 2 : 0,
              DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 32'd5 : 32'd0);
    runDivide("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 33 : 0,
              DIV_EN ? 32'h80000000 : 32'd0, 32'd0);

    // Annul in the tenth busy cycle, then confirm the divider sits idle.
    applyStimulus(SEL_DIV, OP_DIVU, 32'd1000, 32'd3, 5'd4, 1'b1, 1'b0);
    checkOutput("annul_start_stall", {31'd0, stallReq}, {31'd0, DIV_EN});
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    annul = 1'b1;
    #1;
    checkOutput("annul_stall", {31'd0, stallReq}, 32'd0);
    checkOutput("annul_whilo", {31'd0, whilo}, 32'd0);
    applyStimulus(SEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("annul_idle_stall", {31'd0, stallReq}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (whilo === 1'b1 || stallReq === 1'b1) pulses++;
    end
    checkOutput("annul_no_pulse", 32'(pulses), 32'd0);
    runDivide("post_annul_zero", OP_DIVU, 32'd5, 32'd0, DIV_EN ? 2 : 0,
              DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 32'd5 : 32'd0);

    // Reset in the twentieth busy cycle clears every output at once.
    applyStimulus(SEL_DIV, OP_DIVU, 32'd100, 32'd7, 5'd4, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    checkOutput("prerst_stall", {31'd0, stallReq}, {31'd0, DIV_EN});
    rst = 1'b0;
    #1;
    checkOutput("midrst_stall", {31'd0, stallReq}, 32'd0);
    checkOutput("midrst_wd", {27'd0, wdOut}, 32'd0);
    checkOutput("midrst_whilo", {31'd0, whilo}, 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(SEL_ARITH, OP_ADDU, 32'd1, 32'd2, 5'd11, 1'b1, 1'b0);
    checkOutput("postrst_addu", wdata, 32'd3);
    checkOutput("postrst_stall", {31'd0, stallReq}, 32'd0);
    checkOutput("postrst_wreg", {31'd0, wregOut}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (whilo === 1'b1 || stallReq === 1'b1) pulses++;
    end
    checkOutput("postrst_no_pulse", 32'(pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline.
- Consumes the registered decode bundle (alusel, aluop, two operands, destination address, write enable) from the ID/EX pipeline register.
- Produces the GPR write-back bundle and a HI/LO write for the EX/MEM register.
- Contains a multi-cycle radix-2 restoring divider (DIV/DIVU). While the divider runs, the block raises a stall request so that the upstream registers hold.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles in the divider; must equal the data width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- alusel_i  in  3  result class: 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH, 101 DIV
- aluop_i  in  8  operation code
- reg1_i  in  32  operand 1; for shifts, the shift amount in bits [4:0]
- reg2_i  in  32  operand 2
- wd_i  in  5  destination GPR address
- wreg_i  in  1  GPR write enable
- annul_i  in  1  flush; aborts an in-flight divide
- wd_o  out  5  destination GPR address
- wreg_o  out  1  GPR write enable
- wdata_o  out  32  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- stallreq_o  out  1  request to hold PC, IF/ID and ID/EX

Behaviour:
- Datapath outputs are combinational from the inputs and divider state. While rst=0 every output is 0 and the FSM is held in IDLE.
- wd_o = wd_i. wreg_o = wreg_i, except it is forced to 0 for alusel 101 and for NOP.
- LOGIC:
  - OR 00100101
  - AND 00100100
  - XOR 00100110
  - NOR 00100111
- SHIFT (reg2 shifted by reg1[4:0]):
  - SLL 01111100
  - SRL 00000010
  - SRA 00000011 (arithmetic)
- ARITH:
  - ADDU 00100001: modulo-2^32 add
  - SUBU 00100011: modulo-2^32 subtract
  - SLT 00101010: signed compare, result 0 or 1
  - SLTU 00101011: unsigned compare, result 0 or 1
- Any unknown aluop: wdata_o = 0, whilo_o = 0.
- Divider opcodes: DIV 00011010 (signed), DIVU 00011011 (unsigned).
- Divider FSM states: IDLE, BUSY, ZERO, DONE.
  - IDLE, divide op present, annul_i=0: if reg2=0 go to ZERO, otherwise latch operand magnitudes and the sign flags, clear the counter, and go to BUSY. stallreq_o=1 in this cycle.
  - BUSY: one shift/subtract step per cycle; counter increments. Go to DONE once DIV_CYCLES steps have completed. stallreq_o=1.
  - ZERO: quotient = FFFFFFFF, remainder = dividend. Go to DONE next cycle. stallreq_o=1.
  - DONE: stallreq_o=0 and whilo_o=1 with the result on hi_o/lo_o for exactly one cycle, then go to IDLE.
- Latency: a nonzero divide issued in cycle 0 reaches DONE in cycle 33, giving 33 stall cycles. Divide by zero stalls for 2 cycles.
- Signed result fix-up: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
  - 80000000 / FFFFFFFF gives quotient 80000000, remainder 0 (wraps, no trap).
- annul_i=1 in any non-IDLE state: go to IDLE next cycle, stallreq_o=0 immediately, whilo_o=0.
- Operands are latched at start. Input changes during BUSY are ignored, since the upstream is stalled.
- Asserting rst mid-divide aborts immediately. No HI/LO write occurs.

Optional Feature:
- Macro EX_DIV_EN.
- Defined: the divider and FSM are built as described above.
- Undefined: no divider logic. DIV/DIVU produce whilo_o=0, hi_o=lo_o=0, stallreq_o=0, and behave as single-cycle NOPs.

Test Plan:
- ORI path: alusel 001, aluop OR, reg1=0000FF00, reg2=00F0000F, wd=3, wreg=1 -> same cycle wdata=00F0FF0F, wd_o=3, wreg_o=1.
- SRA: reg1=4, reg2=F0000000 -> wdata=FF000000. SLT with FFFFFFFF vs 1 -> 1. SLTU with the same operands -> 0.
- DIVU 100/7 -> stallreq high for 33 cycles, then one cycle with whilo=1, lo=0000000E, hi=00000002, wreg_o=0.
- DIV FFFFFFF9 (-7) / 2 -> lo=FFFFFFFD, hi=FFFFFFFF after 33 stall cycles. Divide by 0 with dividend 5 -> 2 stall cycles, lo=FFFFFFFF, hi=5.
- Start DIVU, assert annul_i in BUSY cycle 10 -> stallreq drops that cycle, FSM in IDLE next cycle, no whilo pulse.
- Assert rst low in BUSY cycle 20 -> all outputs 0 immediately. After release, a new ADDU 1+2 gives 3 with no stall.
